fp_add_arbiter: RTL

Shares one float32 (IEEE 754 binary32) adder between NUM_REQ requesters. Each requester uses a valid/ready request port. The arbiter grants one requester at a time in round-robin order and drives the shared adder operands from registers. It captures the sum after ADD_LATENCY cycles and returns it on a single tagged response port with backpressure. It sits between the client blocks and the team's float32 add unit, which is instantiated outside this block.

---
 rtl/fp_arb_pkg.sv | 13 +
 rtl/fp_add_arbiter_rr_pick.sv | 31 +++
 rtl/fp_add_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the float32 adder arbiter.
package fp_arb_pkg;

  localparam int          FP32_W    = 32;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } arbState_e;

endpackage

// File: rtl/fp_add_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any
);

  int cand;

  // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[cand]) begin
        any              = 1'b1;
        gnt_idx          = ID_W'(cand);
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one external float32 adder among NUM_REQ requesters.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 1,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FP32_W-1:0] req_a,
  input  logic [NUM_REQ*FP32_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [FP32_W-1:0]         add_a,
  output logic [FP32_W-1:0]         add_b,
  input  logic [FP32_W-1:0]         add_sum,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [FP32_W-1:0]         rsp_sum,
  input  logic                      rsp_ready,
  output logic                      busy,
  output logic [15:0]               op_count
);

  localparam int CNT_W = $clog2(ADD_LATENCY + 1);

  arbState_e          state, nextState;
  logic [ID_W-1:0]    rrPtr;
  logic [ID_W-1:0]    gntIdx;
  logic [NUM_REQ-1:0] gntOnehot;
  logic               gntAny;
  logic [CNT_W-1:0]   waitCnt;
  logic               lastWait;
  logic               rspDone;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (req_valid),
    .ptr        (rrPtr),
    .gnt_onehot (gntOnehot),
    .gnt_idx    (gntIdx),
    .any        (gntAny)
  );

  assign lastWait = (waitCnt == CNT_W'(1));
  assign rspDone  = (state == RESP) && rsp_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    nextState = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (gntAny) begin
          req_ready = gntOnehot;
          nextState = WAIT;
        end
      end
      WAIT:    if (lastWait) nextState = RESP;
      RESP:    if (rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rrPtr     <= '0;
      add_a     <= FP32_ZERO;
      add_b     <= FP32_ZERO;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= FP32_ZERO;
      op_count  <= '0;
      waitCnt   <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && gntAny) begin
        add_a   <= req_a[FP32_W*gntIdx +: FP32_W];
        add_b   <= req_b[FP32_W*gntIdx +: FP32_W];
        rsp_id  <= gntIdx;
        waitCnt <= CNT_W'(ADD_LATENCY);
      end
      if (state == WAIT) begin
        waitCnt <= waitCnt - 1'b1;
        if (lastWait) begin
          rsp_sum   <= add_sum;
          rsp_valid <= 1'b1;
        end
      end
      // Pointer moves only on completion, so a granted requester cannot be skipped twice.
      if (rspDone) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 16'd1;
        rrPtr     <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
      end
    end
  end

endmodule
